sar_adc_logic: RTL and testbench
================================

# sar_adc_logic

Digital controller for an 8-bit differential charge-redistribution SAR ADC. On a convert-start request it drives the sampling phase, then runs 8 binary-search bit cycles. Each bit cycle strobes the comparator and updates the capacitor-array switch vectors for two split capacitor arrays (sca1 = positive side, sca2 = negative side). It sits between the host/sequencer, which issues `cnvst` and reads `sar`/`eoc`, and the analog front end (comparator and capacitor switches).

## Interface
- `SAMPLE_CYCLES`, default 2: number of clock cycles `s_clk` is held high; legal range ≥1.
- `clk` in 1: single system clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `cnvst` in 1: convert start, level-sampled on `clk`.
- `cmp_out` in 1: comparator result; 1 means DAC voltage > input, so the trial bit is cleared.
- `sar` out 8: trial/result code, MSB first.
- `eoc` out 1: end of conversion.
- `cmp_clk` out 1: comparator strobe, registered.
- `s_clk` out 1: sample switch control, registered.
- `fine_sca1_top` out 9: sca1 top-plate sampling switches; 1 = closed.
- `fine_sca1_btm` out 9: sca1 bottom-plate switches; 1 = VREF, 0 = GND.
- `fine_sca2_top` out 9: sca2 top-plate sampling switches.
- `fine_sca2_btm` out 9: sca2 bottom-plate switches.

## Operation
- States: IDLE, SAMPLE, CONV, DONE.
- IDLE, `cnvst`=1 at an edge: enter SAMPLE. Clear `sar` and `eoc`. Set `s_clk`=1 and both top vectors to 9'h1FF.
- SAMPLE: hold for `SAMPLE_CYCLES` cycles. On leaving:
  - `s_clk`=0, top vectors = 0.
  - `sar`=8'h80, bit index = 7, `cmp_clk`=1. Enter CONV.
- CONV, per bit, two cycles:
  - Cycle 1: `cmp_clk`=1. At its closing edge, sample `cmp_out`. If 1, clear bit[idx]. In the same edge, set bit[idx-1] as the new trial and drive `cmp_clk`=0.
  - Cycle 2: `cmp_clk`=0; array settling.
- After bit 0 is decided: enter DONE. `eoc`=1, `sar` holds the final code. Next edge: IDLE.
- Cap mapping (combinational from `sar` in CONV/DONE):
  - `fine_sca1_btm` = {`sar`, 1'b0}.
  - `fine_sca2_btm` = {~`sar`, 1'b0}.
  - Bit 0 is the dummy LSB cap, always 0.
  - In IDLE and SAMPLE, both btm vectors = 0.
- `cnvst` is ignored outside IDLE; no restart mid-conversion.
- `sar` and `eoc` hold their values in IDLE until the next start.

## Timing
- Reset values: `sar`=0, `eoc`=0, `cmp_clk`=0, `s_clk`=0, all four cap vectors = 0, state IDLE.
- Reset asserted mid-conversion: immediately return to reset values; no partial result retained.
- Start edge E0 is the first rising edge in IDLE with `cnvst`=1. With S = `SAMPLE_CYCLES`:
  - `s_clk` high from E0 to E(S).
  - Bit 7−j is decided at edge E(S+1+2j).
  - Final code and `eoc`=1 at E(S+15); IDLE at E(S+16).
- Default latency: 17 cycles from start edge to `eoc`.
- `cnvst` held high through DONE/IDLE starts a new conversion at the first IDLE edge where it is still high.

## Configuration
- `SAR_EOC_PULSE_EN` defined: `eoc` is a single-cycle pulse in DONE only.
- Not defined: `eoc` stays high from DONE until the next start edge or reset.

## Structure
- Package `sar_logic_pkg` holds:
  - State enum (IDLE/SAMPLE/CONV/DONE).
  - `SAR_BITS`=8, `CAP_W`=9.
  - Dummy-cap bit position.
- One sub-module, `sar_cap_map`: combinational mapping from `sar`/state to the four 9-bit switch vectors.

## Test plan
- Reset held low with `cnvst`=1 -> all outputs 0, no conversion starts. Release reset, then `cnvst` for 2 cycles -> `s_clk` high for exactly 2 cycles, top vectors 9'h1FF while `s_clk` high.
- `cmp_out`=0 constant -> `sar`=8'hFF, `eoc` high 17 cycles after the start edge. `fine_sca1_btm`=9'h1FE, `fine_sca2_btm`=9'h000.
- `cmp_out`=1 constant -> `sar`=8'h00, `fine_sca2_btm`=9'h1FE at DONE.
- Comparator model with input code 8'hA5 (`cmp_out` = trial>input) -> final `sar`=8'hA5. Exactly 8 `cmp_clk` pulses, each 1 cycle high, 1 low.
- `cnvst` re-pulsed mid-CONV -> ignored, result unchanged. Reset asserted mid-CONV -> outputs 0 asynchronously.
- With/without `SAR_EOC_PULSE_EN` -> `eoc` width 1 cycle vs. held until the next start edge.

Source files
------------

// File: rtl/sar_logic_pkg.sv
// rtl/sar_logic_pkg.sv - shared widths, state encoding and cap-array constants for the SAR controller
package sar_logic_pkg;

    localparam int SAR_BITS  = 8;
    localparam int CAP_W     = 9;
    // Position of the dummy LSB capacitor in every switch vector; never switched to VREF.
    localparam int DUMMY_BIT = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_CONV   = 2'd2,
        ST_DONE   = 2'd3
    } sar_state_t;

endpackage

// File: rtl/sar_cap_map.sv
// rtl/sar_cap_map.sv - combinational mapping from SAR code and state to the split-array switch vectors
module sar_cap_map
    import sar_logic_pkg::*;
(
    input  sar_state_t          i_state,
    input  logic [SAR_BITS-1:0] i_sar,
    output logic [CAP_W-1:0]    o_sca1_top,
    output logic [CAP_W-1:0]    o_sca1_btm,
    output logic [CAP_W-1:0]    o_sca2_top,
    output logic [CAP_W-1:0]    o_sca2_btm
);

    // Top plates close only while sampling; bottom plates follow the trial code
    // (sca1 true, sca2 complemented) once the binary search has begun.
    always_comb begin
        o_sca1_top = '0;
        o_sca2_top = '0;
        o_sca1_btm = '0;
        o_sca2_btm = '0;
        if (i_state == ST_SAMPLE) begin
            o_sca1_top = '1;
            o_sca2_top = '1;
        end
        if ((i_state == ST_CONV) || (i_state == ST_DONE)) begin
            o_sca1_btm            = {i_sar, 1'b0};
            o_sca2_btm            = {~i_sar, 1'b0};
            o_sca1_btm[DUMMY_BIT] = 1'b0;
            o_sca2_btm[DUMMY_BIT] = 1'b0;
        end
    end

endmodule

// File: rtl/sar_adc_logic.sv
// rtl/sar_adc_logic.sv - 8-bit SAR ADC sequencer (optional SAR_EOC_PULSE_EN: single-cycle eoc)
module sar_adc_logic
    import sar_logic_pkg::*;
#(
    parameter int SAMPLE_CYCLES = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_cnvst,
    input  logic                i_cmp_out,
    output logic [SAR_BITS-1:0] o_sar,
    output logic                o_eoc,
    output logic                o_cmp_clk,
    output logic                o_s_clk,
    output logic [CAP_W-1:0]    o_fine_sca1_top,
    output logic [CAP_W-1:0]    o_fine_sca1_btm,
    output logic [CAP_W-1:0]    o_fine_sca2_top,
    output logic [CAP_W-1:0]    o_fine_sca2_btm
);

    localparam int CNT_W = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SMP_LAST = CNT_W'(SAMPLE_CYCLES - 1);

    sar_state_t          r_state;
    logic [SAR_BITS-1:0] r_sar;
    logic [2:0]          r_idx;
    logic [CNT_W-1:0]    r_smp_cnt;
    logic                r_eoc;
    logic                r_cmp_clk;
    logic                r_s_clk;
    logic [SAR_BITS-1:0] w_sar_dec;

    // Code after the current bit decision: drop the trial bit if the DAC overshot,
    // and raise the next lower bit as the new trial (none after bit 0).
    always_comb begin
        w_sar_dec = r_sar;
        if (i_cmp_out) begin
            w_sar_dec[r_idx] = 1'b0;
        end
        if (r_idx != 3'd0) begin
            w_sar_dec[r_idx - 3'd1] = 1'b1;
        end
    end

    // Conversion sequencer: sample window, then two cycles per bit (strobe, settle).
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state   <= ST_IDLE;
            r_sar     <= '0;
            r_idx     <= '0;
            r_smp_cnt <= '0;
            r_eoc     <= 1'b0;
            r_cmp_clk <= 1'b0;
            r_s_clk   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_cnvst) begin
                        r_state   <= ST_SAMPLE;
                        r_sar     <= '0;
                        r_eoc     <= 1'b0;
                        r_s_clk   <= 1'b1;
                        r_smp_cnt <= '0;
                    end
                end
                ST_SAMPLE: begin
                    if (r_smp_cnt == SMP_LAST) begin
                        r_state   <= ST_CONV;
                        r_s_clk   <= 1'b0;
                        r_sar     <= 8'h80;
                        r_idx     <= 3'd7;
                        r_cmp_clk <= 1'b1;
                    end else begin
                        r_smp_cnt <= r_smp_cnt + 1'b1;
                    end
                end
                ST_CONV: begin
                    if (r_cmp_clk) begin
                        r_sar     <= w_sar_dec;
                        r_cmp_clk <= 1'b0;
                        if (r_idx == 3'd0) begin
                            r_state <= ST_DONE;
                            r_eoc   <= 1'b1;
                        end else begin
                            r_idx <= r_idx - 3'd1;
                        end
                    end else begin
                        r_cmp_clk <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
`ifdef SAR_EOC_PULSE_EN
                    r_eoc   <= 1'b0;
`endif
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_sar     = r_sar;
    assign o_eoc     = r_eoc;
    assign o_cmp_clk = r_cmp_clk;
    assign o_s_clk   = r_s_clk;

    sar_cap_map u_cap_map (
        .i_state    (r_state),
        .i_sar      (r_sar),
        .o_sca1_top (o_fine_sca1_top),
        .o_sca1_btm (o_fine_sca1_btm),
        .o_sca2_top (o_fine_sca2_top),
        .o_sca2_btm (o_fine_sca2_btm)
    );

endmodule

// File: tb/tb_sar_adc_logic.sv
// tb/tb_sar_adc_logic.sv - directed self-checking bench for sar_adc_logic
module tb_sar_adc_logic;

`ifdef SAR_EOC_PULSE_EN
    localparam int EXP_EOC_W = 1;
`else
    localparam int EXP_EOC_W = 14;
`endif

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic       i_cnvst = 1'b0;
    logic [1:0] cmp_mode = 2'd0;
    logic [7:0] vin = 8'h00;
    logic       w_cmp;
    logic [7:0] o_sar;
    logic       o_eoc, o_cmp_clk, o_s_clk;
    logic [8:0] t1, b1, t2, b2;

    int errors = 0;
    int checks = 0;

    int         r_eoc_k, r_s_cnt, r_top_cnt, r_cmp_hi, r_cmp_rise, r_eoc_w;
    logic       r_eoc_start;
    logic [7:0] r_sar_done, r_sar_end;
    logic [8:0] r_b1_done, r_b2_done, r_b1_end, r_b2_end;

    // Comparator front end: constant 0/1, or ideal model comparing trial code to vin.
    assign w_cmp = (cmp_mode == 2'd2) ? (o_sar > vin) : cmp_mode[0];

    always #5 i_clk = ~i_clk;

    sar_adc_logic #(.SAMPLE_CYCLES(2)) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_cnvst         (i_cnvst),
        .i_cmp_out       (w_cmp),
        .o_sar           (o_sar),
        .o_eoc           (o_eoc),
        .o_cmp_clk       (o_cmp_clk),
        .o_s_clk         (o_s_clk),
        .o_fine_sca1_top (t1),
        .o_fine_sca1_btm (b1),
        .o_fine_sca2_top (t2),
        .o_fine_sca2_btm (b2)
    );

    task automatic run_conv(input int pulse_at);
        logic prev_cmp;
        @(negedge i_clk);
        i_cnvst = 1'b1;
        @(posedge i_clk);
        #1;
        i_cnvst     = 1'b0;
        r_eoc_start = o_eoc;
        r_s_cnt     = o_s_clk ? 1 : 0;
        r_top_cnt   = (t1 == 9'h1FF && t2 == 9'h1FF) ? 1 : 0;
        r_cmp_hi    = 0;
        r_cmp_rise  = 0;
        r_eoc_w     = 0;
        r_eoc_k     = -1;
        prev_cmp    = o_cmp_clk;
        for (int k = 1; k <= 30; k++) begin
            @(posedge i_clk);
            #1;
            if (k == pulse_at) i_cnvst = 1'b1;
            if (k == pulse_at + 2) i_cnvst = 1'b0;
            if (o_s_clk) r_s_cnt++;
            if (t1 == 9'h1FF && t2 == 9'h1FF) r_top_cnt++;
            if (o_cmp_clk) r_cmp_hi++;
            if (o_cmp_clk && !prev_cmp) r_cmp_rise++;
            prev_cmp = o_cmp_clk;
            if (o_eoc) r_eoc_w++;
            if (o_eoc && r_eoc_k < 0) begin
                r_eoc_k    = k;
                r_sar_done = o_sar;
                r_b1_done  = b1;
                r_b2_done  = b2;
            end
        end
        r_sar_end = o_sar;
        r_b1_end  = b1;
        r_b2_end  = b2;
    endtask

    task automatic test_reset();
        int s_cnt, top_cnt;
        i_rst   = 1'b0;
        i_cnvst = 1'b1;
        repeat (4) @(posedge i_clk);
        #1;
        checks++;
        if ({o_sar, o_eoc, o_cmp_clk, o_s_clk, t1, b1, t2, b2} !== 47'd0) begin
            errors++;
            $display("FAIL reset_outputs got sar=%h eoc=%b cmp=%b s=%b t1=%h b1=%h t2=%h b2=%h exp all 0",
                     o_sar, o_eoc, o_cmp_clk, o_s_clk, t1, b1, t2, b2);
        end
        @(negedge i_clk);
        i_cnvst = 1'b0;
        i_rst   = 1'b1;
        @(negedge i_clk);
        i_cnvst = 1'b1;
        s_cnt   = 0;
        top_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge i_clk);
            #1;
            if (k == 1) i_cnvst = 1'b0;
            if (o_s_clk) s_cnt++;
            if (t1 == 9'h1FF && t2 == 9'h1FF) top_cnt++;
        end
        checks++;
        if (s_cnt !== 2) begin
            errors++;
            $display("FAIL sample_width got %0d exp 2", s_cnt);
        end
        checks++;
        if (top_cnt !== 2) begin
            errors++;
            $display("FAIL top_vectors_1ff got %0d cycles exp 2", top_cnt);
        end
        repeat (30) @(posedge i_clk);
    endtask

    task automatic test_cmp_zero();
        cmp_mode = 2'd0;
        run_conv(-10);
        checks++;
        if (r_eoc_k !== 17) begin
            errors++;
            $display("FAIL eoc_latency got %0d exp 17", r_eoc_k);
        end
        checks++;
        if (r_sar_done !== 8'hFF) begin
            errors++;
            $display("FAIL zero_sar got %h exp ff", r_sar_done);
        end
        checks++;
        if (r_b1_done !== 9'h1FE || r_b2_done !== 9'h000) begin
            errors++;
            $display("FAIL zero_btm got sca1=%h sca2=%h exp 1fe 000", r_b1_done, r_b2_done);
        end
        checks++;
        if (r_s_cnt !== 2 || r_top_cnt !== 2) begin
            errors++;
            $display("FAIL zero_sample got s=%0d top=%0d exp 2 2", r_s_cnt, r_top_cnt);
        end
    endtask

    task automatic test_cmp_one();
        cmp_mode = 2'd1;
        run_conv(-10);
        checks++;
        if (r_eoc_start !== 1'b0) begin
            errors++;
            $display("FAIL eoc_clear_on_start got %b exp 0", r_eoc_start);
        end
        checks++;
        if (r_sar_done !== 8'h00) begin
            errors++;
            $display("FAIL one_sar got %h exp 00", r_sar_done);
        end
        checks++;
        if (r_b2_done !== 9'h1FE || r_b1_done !== 9'h000) begin
            errors++;
            $display("FAIL one_btm got sca1=%h sca2=%h exp 000 1fe", r_b1_done, r_b2_done);
        end
    endtask

    task automatic test_code_a5();
        cmp_mode = 2'd2;
        vin      = 8'hA5;
        run_conv(-10);
        checks++;
        if (r_sar_done !== 8'hA5) begin
            errors++;
            $display("FAIL a5_sar got %h exp a5", r_sar_done);
        end
        checks++;
        if (r_cmp_hi !== 8 || r_cmp_rise !== 8) begin
            errors++;
            $display("FAIL a5_cmp_pulses got high=%0d rises=%0d exp 8 8", r_cmp_hi, r_cmp_rise);
        end
        checks++;
        if (r_eoc_w !== EXP_EOC_W) begin
            errors++;
            $display("FAIL eoc_width got %0d exp %0d", r_eoc_w, EXP_EOC_W);
        end
        checks++;
        if (r_sar_end !== 8'hA5 || r_b1_end !== 9'h000 || r_b2_end !== 9'h000) begin
            errors++;
            $display("FAIL idle_hold got sar=%h b1=%h b2=%h exp a5 000 000", r_sar_end, r_b1_end, r_b2_end);
        end
    endtask

    task automatic test_cnvst_ignored();
        cmp_mode = 2'd2;
        vin      = 8'h3C;
        run_conv(6);
        checks++;
        if (r_sar_done !== 8'h3C || r_eoc_k !== 17) begin
            errors++;
            $display("FAIL cnvst_mid_conv got sar=%h eoc_k=%0d exp 3c 17", r_sar_done, r_eoc_k);
        end
    endtask

    task automatic test_reset_mid();
        cmp_mode = 2'd2;
        vin      = 8'h5A;
        @(negedge i_clk);
        i_cnvst = 1'b1;
        @(posedge i_clk);
        #1;
        i_cnvst = 1'b0;
        repeat (8) @(posedge i_clk);
        #2;
        checks++;
        if (o_sar === 8'h00) begin
            errors++;
            $display("FAIL mid_conv_active got sar=%h exp nonzero", o_sar);
        end
        i_rst = 1'b0;
        #1;
        checks++;
        if ({o_sar, o_eoc, o_cmp_clk, o_s_clk, t1, b1, t2, b2} !== 47'd0) begin
            errors++;
            $display("FAIL async_reset got sar=%h eoc=%b cmp=%b s=%b b1=%h b2=%h exp all 0",
                     o_sar, o_eoc, o_cmp_clk, o_s_clk, b1, b2);
        end
        @(negedge i_clk);
        i_rst = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        checks++;
        if (o_s_clk !== 1'b0 || o_cmp_clk !== 1'b0 || o_sar !== 8'h00) begin
            errors++;
            $display("FAIL no_restart got s=%b cmp=%b sar=%h exp 0 0 00", o_s_clk, o_cmp_clk, o_sar);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] sar17;
        logic       s18, s19, eoc19;
        cmp_mode = 2'd0;
        sar17    = 8'h00;
        s18      = 1'b1;
        s19      = 1'b0;
        eoc19    = 1'b1;
        @(negedge i_clk);
        i_cnvst = 1'b1;
        @(posedge i_clk);
        for (int k = 1; k <= 19; k++) begin
            @(posedge i_clk);
            #1;
            if (k == 17) sar17 = o_sar;
            if (k == 18) s18 = o_s_clk;
            if (k == 19) begin
                s19   = o_s_clk;
                eoc19 = o_eoc;
            end
        end
        i_cnvst = 1'b0;
        checks++;
        if (sar17 !== 8'hFF) begin
            errors++;
            $display("FAIL b2b_first_code got %h exp ff", sar17);
        end
        checks++;
        if (s18 !== 1'b0 || s19 !== 1'b1 || eoc19 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_restart got s18=%b s19=%b eoc19=%b exp 0 1 0", s18, s19, eoc19);
        end
        repeat (25) @(posedge i_clk);
    endtask

    initial begin
        test_reset();
        test_cmp_zero();
        test_cmp_one();
        test_code_a5();
        test_cnvst_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
